// File: rtl/miss_fetch_pkg.sv
// Shared cache types for the miss-fetch path: controller states, word
// width and the block-offset helper used to align fill addresses.
package miss_fetch_pkg;

    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = WORD_W / 8;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAZARD = 2'd1,
        FETCH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of low address bits covered by one cache block.
    function automatic int blk_off(input int block_words);
        return $clog2(WORD_BYTES * block_words);
    endfunction

endpackage

// File: rtl/miss_fetch_fill_buffer.sv
// Word counter and block assembly register for a cache fill.
// Words land at the position given by the counter; a whole-block load
// overrides the assembly (used by write-queue forwarding).
module fill_buffer
    import miss_fetch_pkg::*;
#(
    parameter  int BLOCK_WORDS = 2,
    localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        load,
    input  logic [WORD_W-1:0]           data,
    input  logic                        blk_load,
    input  logic [WORD_W*BLOCK_WORDS-1:0] blk_data,
    output logic [IDX_W-1:0]            index,
    output logic [WORD_W*BLOCK_WORDS-1:0] block,
    output logic                        last
);

    logic [IDX_W-1:0] cnt;

    // Counter and assembly register; the block is only overwritten word by
    // word, so the previous fill stays visible until new words arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            block <= '0;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (load) begin
                cnt <= cnt + IDX_W'(1);
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    if (cnt == IDX_W'(i)) begin
                        block[i*WORD_W +: WORD_W] <= data;
                    end
                end
            end
            if (blk_load) begin
                block <= blk_data;
            end
        end
    end

    assign index = cnt;
    assign last  = (cnt == IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/miss_fetch.sv
// Cache miss block-fill controller. Waits out a pending dirty write-queue
// entry for the block, reads the block word by word from memory and
// presents it for one cycle.
// Optional feature: define WQ_FORWARD_EN to satisfy a miss that hits the
// write queue directly from wq_data, skipping memory entirely.
module miss_fetch
    import miss_fetch_pkg::*;
#(
    parameter  int ADDR_W      = 32,
    parameter  int BLOCK_WORDS = 2,
    localparam int BLK_W       = WORD_W * BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              dmiss,
    input  logic [ADDR_W-1:0] dmissaddr,
    output logic              dmissREN,
    output logic [ADDR_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              dwait,
    input  logic              wq_match,
    input  logic [BLK_W-1:0]  wq_data,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [BLK_W-1:0]  fill_block,
    output logic              busy
);

    localparam int OFF_W = blk_off(BLOCK_WORDS);
    localparam int IDX_W = $clog2(BLOCK_WORDS);

    state_t             state, nxt;
    logic [ADDR_W-1:0]  base;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic               start;
    logic               rd_done;
    logic               fwd_load;
    logic [BLK_W-1:0]   fwd_data;

    assign start   = (state == IDLE) && dmiss;
    assign rd_done = (state == FETCH) && !dwait;

`ifdef WQ_FORWARD_EN
    assign fwd_load = start && wq_match;
    assign fwd_data = wq_data;
`else
    logic unused_wq;
    assign unused_wq = ^wq_data;
    assign fwd_load  = 1'b0;
    assign fwd_data  = '0;
`endif

    fill_buffer #(
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_buf (
        .clk      (clk),
        .rst      (n_rst),
        .clear    (start),
        .load     (rd_done),
        .data     (dmemload),
        .blk_load (fwd_load),
        .blk_data (fwd_data),
        .index    (idx),
        .block    (fill_block),
        .last     (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Block base address, captured block-aligned when a miss is accepted.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            base <= '0;
        end else if (start) begin
            base <= {dmissaddr[ADDR_W-1:OFF_W], OFF_W'(0)};
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (dmiss) begin
`ifdef WQ_FORWARD_EN
                    nxt = wq_match ? DONE : FETCH;
`else
                    nxt = wq_match ? HAZARD : FETCH;
`endif
                end
            end
            HAZARD:  if (!wq_match) nxt = FETCH;
            FETCH:   if (rd_done && last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state; memory is only addressed in FETCH.
    always_comb begin
        dmissREN   = 1'b0;
        dmemaddr   = '0;
        fill_valid = 1'b0;
        busy       = (state != IDLE);
        fill_addr  = base;
        if (state == FETCH) begin
            dmissREN = 1'b1;
            dmemaddr = base + ADDR_W'({idx, {BYTE_OFF_W{1'b0}}});
        end
        if (state == DONE) begin
            fill_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_miss_fetch.sv
// Directed bench for miss_fetch (ADDR_W=32, BLOCK_WORDS=2) with a
// combinational memory model and hand-derived expected timing/data.
module tb_miss_fetch;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        dmiss;
    logic [31:0] dmissaddr;
    logic        dmissREN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemload;
    logic        dwait;
    logic        wq_match;
    logic [63:0] wq_data;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [63:0] fill_block;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    miss_fetch #(
        .ADDR_W      (32),
        .BLOCK_WORDS (2)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .dmiss      (dmiss),
        .dmissaddr  (dmissaddr),
        .dmissREN   (dmissREN),
        .dmemaddr   (dmemaddr),
        .dmemload   (dmemload),
        .dwait      (dwait),
        .wq_match   (wq_match),
        .wq_data    (wq_data),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_block (fill_block),
        .busy       (busy)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_1230: return 32'hAAAA_0001;
            32'h0000_1234: return 32'hBBBB_0002;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign dmemload = mem_rd(dmemaddr);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One fill: stalls = dwait cycles per word, hz = cycles wq_match held,
    // noise = keep dmiss high with a different address while busy.
    task automatic run_fill(input logic [31:0] addr, input int stalls, input int hz, input bit noise);
        logic [31:0] base;
        logic [63:0] exp_blk;
        int          exp_lat, lat, nread, scnt, hzleft;
        bit          seen;
        base    = addr & ~32'h7;
        exp_blk = {mem_rd(base + 32'h4), mem_rd(base)};
        exp_lat = 4 + 2 * stalls + hz;
        dmiss = 1'b1; dmissaddr = addr; wq_match = (hz > 0); dwait = 1'b0;
        lat = 0; nread = 0; scnt = 0; hzleft = hz; seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            dmiss = noise;
            if (noise) dmissaddr = 32'hDEAD_BEE0;
            if (hzleft > 0) begin
                chk("hazard_ren", dmissREN, 1'b0);
                hzleft--;
                if (hzleft == 0) wq_match = 1'b0;
            end
            if (dmissREN) begin
                chk("memaddr", dmemaddr, base + 32'(4 * nread));
                if (scnt < stalls) begin
                    dwait = 1'b1; scnt++;
                end else begin
                    dwait = 1'b0; scnt = 0; nread++;
                end
            end else begin
                dwait = 1'b0;
            end
            if (fill_valid) begin
                seen = 1'b1;
                dmiss = 1'b0;
                chk("latency", lat + 1, exp_lat);
                chk("fill_addr", fill_addr, base);
                chk("fill_block", fill_block, exp_blk);
                chk("reads", nread, 2);
            end
        end
        if (!seen) chk("fill_timeout", 0, 1);
        @(posedge clk); #1;
        chk("pulse_one_cycle", fill_valid, 1'b0);
        chk("idle_after", busy, 1'b0);
        chk("block_stable", fill_block, exp_blk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, idles;
        bit prev_fv, dbl;
        n_rst = 1'b1; dmiss = 1'b0; dmissaddr = '0; dwait = 1'b0;
        wq_match = 1'b0; wq_data = 64'h1111_2222_3333_4444;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ren", dmissREN, 1'b0);
        chk("rst_fv", fill_valid, 1'b0);
        chk("rst_block", fill_block, 64'h0);
        chk("rst_addr", fill_addr, 32'h0);
        chk("rst_memaddr", dmemaddr, 32'h0);
        n_rst = 1'b0;

        // Basic fill, then stalled fill with dmiss noise while busy.
        run_fill(32'h0000_1234, 0, 0, 1'b0);
        run_fill(32'h0000_1234, 3, 0, 1'b1);

`ifndef WQ_FORWARD_EN
        // Write-queue hazard held for 5 cycles.
        run_fill(32'h0000_1234, 0, 5, 1'b0);
`else
        // Forwarding straight from the write queue.
        dmiss = 1'b1; dmissaddr = 32'h0000_0044; wq_match = 1'b1;
        @(posedge clk); #1;
        chk("fwd_fv", fill_valid, 1'b1);
        chk("fwd_ren", dmissREN, 1'b0);
        chk("fwd_addr", fill_addr, 32'h0000_0040);
        chk("fwd_block", fill_block, 64'h1111_2222_3333_4444);
        dmiss = 1'b0; wq_match = 1'b0;
        @(posedge clk); #1;
        chk("fwd_idle", busy, 1'b0);
`endif

        // Reset during the second word read.
        dmiss = 1'b1; dmissaddr = 32'h0000_2000; dwait = 1'b0;
        @(posedge clk); #1;
        dmiss = 1'b0;
        @(posedge clk); #1;
        chk("mid_ren", dmissREN, 1'b1);
        chk("mid_addr", dmemaddr, 32'h0000_2004);
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ren", dmissREN, 1'b0);
        chk("abort_fv", fill_valid, 1'b0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (fill_valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        run_fill(32'h0000_2008, 1, 0, 1'b0);

        // dmiss held high: back-to-back fills.
        dmiss = 1'b1; dmissaddr = 32'h0000_1230;
        pulses = 0; idles = 0; prev_fv = 1'b0; dbl = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (fill_valid) begin
                pulses++;
                if (prev_fv) dbl = 1'b1;
                chk("b2b_block", fill_block, 64'hBBBB_0002_AAAA_0001);
            end
            if (!busy) idles++;
            prev_fv = fill_valid;
        end
        dmiss = 1'b0;
        chk("b2b_pulses", pulses, 3);
        chk("b2b_idles", idles, 3);
        chk("b2b_no_double", dbl, 1'b0);
        @(posedge clk); #1;
        chk("b2b_end_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miss_fetch.md
MISS_FETCH -- requirements
Module: miss_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter BLOCK_WORDS, default 2, 32-bit words per cache block; legal values are 2 and 4 only.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port n_rst, input, 1, reset; synchronous, active-high despite its name.
REQ-005 SHALL have port dmiss, input, 1, cache requests a block fill.
REQ-006 SHALL have port dmissaddr, input, ADDR_W, miss byte address.
REQ-007 SHALL have port dmissREN, output, 1, memory read request; the write queue drains only while this is low.
REQ-008 SHALL have port dmemaddr, output, ADDR_W, memory word address.
REQ-009 SHALL have port dmemload, input, 32, memory read data.
REQ-010 SHALL have port dwait, input, 1, memory not ready; a read completes on a cycle with dmissREN=1 and dwait=0.
REQ-011 SHALL have port wq_match, input, 1, write queue holds a dirty entry for the current block address.
REQ-012 SHALL have port wq_data, input, 32*BLOCK_WORDS, newest matching dirty block.
REQ-013 SHALL have port fill_valid, output, 1, one-cycle pulse: block delivered.
REQ-014 SHALL have port fill_addr, output, ADDR_W, block-aligned fill address.
REQ-015 SHALL have port fill_block, output, 32*BLOCK_WORDS, assembled block; word 0 in the least significant bits.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, HAZARD, FETCH, DONE.
REQ-018 In IDLE with dmiss=1, SHALL latch base = dmissaddr with its low log2(4*BLOCK_WORDS) bits cleared, and clear the word counter.
REQ-019 From IDLE, SHALL go to HAZARD if wq_match=1, else to FETCH.
REQ-020 In HAZARD, dmissREN SHALL be 0 so the queue can drain; SHALL go to FETCH on the first cycle with wq_match=0.
REQ-021 In FETCH, dmissREN SHALL be 1 and dmemaddr SHALL equal base + 4*count.
REQ-022 On each completed read, SHALL store dmemload into word[count] and increment count.
REQ-023 After the read of word BLOCK_WORDS-1 completes, SHALL go to DONE; any dwait stall holds state, address and data unchanged.
REQ-024 In DONE, SHALL drive fill_valid=1 for exactly one cycle, with fill_addr=base and fill_block valid; next state is IDLE.
REQ-025 SHALL ignore dmiss outside IDLE; a dmiss held high after DONE starts a new fill from IDLE.
REQ-026 Minimum latency with dwait=0 and no hazard SHALL be BLOCK_WORDS+2 cycles from dmiss sampled to fill_valid.
REQ-027 SHALL drive dmissREN=0 and dmemaddr=0 in every state other than FETCH.
REQ-028 SHALL hold fill_block and fill_addr stable from DONE until the next fill starts.

Reset
REQ-029 On n_rst=1 at a clock edge: state=IDLE, count=0, base=0, fill_block=0, dmissREN=0, fill_valid=0, busy=0.
REQ-030 Reset asserted mid-fill SHALL abandon the fill with no fill_valid pulse; a partial read in flight is dropped.

Configuration
REQ-031 With WQ_FORWARD_EN defined, IDLE with dmiss=1 and wq_match=1 SHALL go directly to DONE, loading fill_block from wq_data with no memory read; latency is 2 cycles.
REQ-032 Without WQ_FORWARD_EN, wq_data SHALL be unused and the HAZARD path of REQ-019/020 applies.

Structure
REQ-033 The state enum, the word width (32) and the block-offset constant SHALL be placed in the shared cache types package.
REQ-034 The word counter and assembly register SHALL be a sub-module named fill_buffer, with ports clear, load, index and data, and outputs block and last.

Verification
REQ-035 dmiss, dmissaddr=0x0000_1234, BLOCK_WORDS=2, dwait=0, mem[0x1230]=0xAAAA_0001, mem[0x1234]=0xBBBB_0002 -> dmemaddr 0x1230 then 0x1234; fill_valid at cycle 4 with fill_addr=0x1230 and fill_block=0xBBBB_0002_AAAA_0001.
REQ-036 Same request with dwait=1 for 3 cycles on each word -> dmemaddr held during stalls; fill_valid at cycle 10 with identical data.
REQ-037 wq_match=1 for 5 cycles, macro undefined -> dmissREN=0 for those 5 cycles, then the FETCH sequence; fill data comes from memory.
REQ-038 WQ_FORWARD_EN defined, wq_match=1, wq_data=0x1111_2222_3333_4444 -> dmissREN never asserted; fill_valid at cycle 2 with that data.
REQ-039 n_rst=1 during the second FETCH read -> next cycle busy=0 and dmissREN=0; no fill_valid pulse; a following miss completes normally.
REQ-040 dmiss held high continuously -> back-to-back fills, with exactly one fill_valid pulse per fill and a return to IDLE between fills.
